// File: rtl/riscv_defines.sv
// Shared interrupt constants for the arbiter and the downstream interrupt controller.
package riscv_defines;

  localparam int IRQ_NUM  = 32;
  localparam int IRQ_ID_W = 5;

  localparam logic [IRQ_ID_W-1:0] IRQ_ID_DEBUG = 5'd12;

endpackage

// File: rtl/riscv_irq_arbiter_if.sv
// Core-facing interrupt request / acknowledge handshake between the arbiter and the controller.
interface riscv_irq_arbiter_if
  import riscv_defines::*;
();

  logic                irq_o;
  logic [IRQ_ID_W-1:0] irq_id_o;
  logic                irq_sec_o;
  logic                irq_ack_i;
  logic [IRQ_ID_W-1:0] irq_ack_id_i;

  modport master (
    output irq_o,
    output irq_id_o,
    output irq_sec_o,
    input  irq_ack_i,
    input  irq_ack_id_i
  );

  modport slave (
    input  irq_o,
    input  irq_id_o,
    input  irq_sec_o,
    output irq_ack_i,
    output irq_ack_id_i
  );

endinterface

// File: rtl/riscv_irq_sync.sv
// Multi-flop bit-vector synchroniser for asynchronous inputs; STAGES is 2 or 3.
module riscv_irq_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int s = 1; s < STAGES; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/riscv_irq_arbiter.sv
// Synchronises 32 interrupt lines, tracks edge/level pending state and presents the
// highest-numbered masked pending line to the interrupt controller as a registered triple.
module riscv_irq_arbiter
  import riscv_defines::*;
#(
  parameter int                 SYNC_STAGES    = 2,
  parameter logic [IRQ_NUM-1:0] RESET_EDGE_CFG = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IRQ_NUM-1:0]  irq_lines_i,
  input  logic [IRQ_NUM-1:0]  irq_edge_cfg_i,
  input  logic [IRQ_NUM-1:0]  irq_mask_i,
  input  logic [IRQ_NUM-1:0]  irq_sec_cfg_i,
  output logic [IRQ_NUM-1:0]  pending_o,
  riscv_irq_arbiter_if.master core
);

  logic [IRQ_NUM-1:0]  sync;
  logic [IRQ_NUM-1:0]  sync_d;
  logic [IRQ_NUM-1:0]  edge_cfg;
  logic [IRQ_NUM-1:0]  edge_pend;
  logic [IRQ_NUM-1:0]  rise;
  logic [IRQ_NUM-1:0]  ack_clr;
  logic [IRQ_NUM-1:0]  pending;
  logic [IRQ_NUM-1:0]  cand;
  logic                win_found;
  logic [IRQ_ID_W-1:0] win_id;
  logic                irq_q;
  logic [IRQ_ID_W-1:0] id_q;
  logic                sec_q;

  riscv_irq_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (IRQ_NUM)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_lines_i),
    .q     (sync)
  );

  assign rise    = sync & ~sync_d;
  assign ack_clr = core.irq_ack_i ? (IRQ_NUM'(1) << core.irq_ack_id_i) : '0;
  assign pending = (edge_pend & edge_cfg) | (sync & ~edge_cfg);
  assign cand    = pending & irq_mask_i;

  // Descending scan: first hit is the highest index; with no candidate the last ID is held.
  always_comb begin
    win_found = 1'b0;
    win_id    = id_q;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (cand[i] && !win_found) begin
        win_found = 1'b1;
        win_id    = IRQ_ID_W'(i);
      end
    end
  end

  // A new rising edge beats a same-cycle acknowledge so no event is lost; level lines never hold edge state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d    <= '0;
      edge_cfg  <= RESET_EDGE_CFG;
      edge_pend <= '0;
      pending_o <= '0;
      irq_q     <= 1'b0;
      id_q      <= '0;
      sec_q     <= 1'b0;
    end else begin
      sync_d    <= sync;
      edge_cfg  <= irq_edge_cfg_i;
      edge_pend <= ((edge_pend & ~ack_clr) | rise) & edge_cfg;
      pending_o <= pending;
      irq_q     <= win_found;
      id_q      <= win_id;
      sec_q     <= irq_sec_cfg_i[win_id];
    end
  end

  assign core.irq_o     = irq_q;
  assign core.irq_id_o  = id_q;
  assign core.irq_sec_o = sec_q;

endmodule
